// File: rtl/tx_os_decoder.sv
// Transmit-side Gen1 ordered-set decoder: recognises TS1/TS2/SKP on the MAC symbol
// stream, publishes TS header fields and counts consecutive identical TS ordered sets.
module tx_os_decoder #(
    parameter int SKP_LEN = 3,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       txdata,
    input  logic             txdatak,
    input  logic             txvalid,
    input  logic             cnt_clr,
    output logic             ts1_det,
    output logic             ts2_det,
    output logic             skp_det,
    output logic             os_err,
    output logic [7:0]       os_link,
    output logic [7:0]       os_lane,
    output logic [7:0]       os_nfts,
    output logic [7:0]       os_rate,
    output logic [7:0]       os_tctl,
    output logic [CNT_W-1:0] ts_cnt,
    output logic             ts_cnt_type
);
    localparam int SKPW = $clog2(SKP_LEN + 1);
    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_PAD = 8'hF7;
    localparam logic [7:0] ID_TS1  = 8'h4A;
    localparam logic [7:0] ID_TS2  = 8'h45;

    typedef enum logic [1:0] {IDLE, HDR, ID, SKP} state_t;

    state_t            state, state_n;
    logic [3:0]        idx, idx_n;
    logic [SKPW-1:0]   skpn, skpn_n, skpn_inc;
    logic [7:0]        sh_link, sh_lane, sh_nfts, sh_rate, sh_tctl;
    logic [7:0]        sh_link_n, sh_lane_n, sh_nfts_n, sh_rate_n, sh_tctl_n;
    logic              sh_type, sh_type_n;
    logic              ts1_n, ts2_n, skp_n, err_n, bad, done, match;
    logic              is_com, is_skp, is_pad, is_d;
    logic [CNT_W-1:0]  cnt_n;
    logic              cnt_type_n;

    assign is_com   = txdatak && (txdata == SYM_COM);
    assign is_skp   = txdatak && (txdata == SYM_SKP);
    assign is_pad   = txdatak && (txdata == SYM_PAD);
    assign is_d     = !txdatak;
    assign skpn_inc = skpn + 1'b1;

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        skpn_n    = skpn;
        sh_link_n = sh_link;
        sh_lane_n = sh_lane;
        sh_nfts_n = sh_nfts;
        sh_rate_n = sh_rate;
        sh_tctl_n = sh_tctl;
        sh_type_n = sh_type;
        ts1_n     = 1'b0;
        ts2_n     = 1'b0;
        skp_n     = 1'b0;
        err_n     = 1'b0;
        bad       = 1'b0;
        if (txvalid) begin
            if (state != IDLE && is_com) begin
                // A new COM aborts the current OS but starts the next one in place.
                err_n   = 1'b1;
                state_n = HDR;
                idx_n   = 4'd1;
            end else begin
                case (state)
                    IDLE: if (is_com) begin
                        state_n = HDR;
                        idx_n   = 4'd1;
                    end
                    HDR: begin
                        case (idx)
                            4'd1: begin
                                if (is_skp) begin
                                    if (SKP_LEN <= 1) begin
                                        skp_n   = 1'b1;
                                        state_n = IDLE;
                                        idx_n   = 4'd0;
                                    end else begin
                                        state_n = SKP;
                                        skpn_n  = SKPW'(1);
                                    end
                                end else if (is_d || is_pad) begin
                                    sh_link_n = txdata;
                                    idx_n     = 4'd2;
                                end else bad = 1'b1;
                            end
                            4'd2: begin
                                if (is_d || is_pad) begin
                                    sh_lane_n = txdata;
                                    idx_n     = 4'd3;
                                end else bad = 1'b1;
                            end
                            default: begin
                                if (is_d) begin
                                    if (idx == 4'd3) sh_nfts_n = txdata;
                                    if (idx == 4'd4) sh_rate_n = txdata;
                                    if (idx == 4'd5) begin
                                        sh_tctl_n = txdata;
                                        state_n   = ID;
                                    end
                                    idx_n = idx + 4'd1;
                                end else bad = 1'b1;
                            end
                        endcase
                    end
                    ID: begin
                        if (idx == 4'd6) begin
                            if (is_d && (txdata == ID_TS1 || txdata == ID_TS2)) begin
                                sh_type_n = (txdata == ID_TS2);
                                idx_n     = 4'd7;
                            end else bad = 1'b1;
                        end else if (is_d && txdata == (sh_type ? ID_TS2 : ID_TS1)) begin
                            if (idx == 4'd15) begin
                                ts1_n   = !sh_type;
                                ts2_n   = sh_type;
                                state_n = IDLE;
                                idx_n   = 4'd0;
                            end else begin
                                idx_n = idx + 4'd1;
                            end
                        end else bad = 1'b1;
                    end
                    SKP: begin
                        if (is_skp) begin
                            skpn_n = skpn_inc;
                            if (skpn_inc == SKPW'(SKP_LEN)) begin
                                skp_n   = 1'b1;
                                state_n = IDLE;
                                idx_n   = 4'd0;
                            end
                        end else bad = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
                if (bad) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                    idx_n   = 4'd0;
                end
            end
        end
    end

    // The shadows of a completing TS are compared against the last published fields.
    assign done  = ts1_n || ts2_n;
    assign match = (sh_type == ts_cnt_type) && (sh_link == os_link) &&
                   (sh_lane == os_lane) && (sh_rate == os_rate);

    always_comb begin
        cnt_n      = ts_cnt;
        cnt_type_n = ts_cnt_type;
        if (done) begin
            if (match) begin
                if (ts_cnt != {CNT_W{1'b1}}) cnt_n = ts_cnt + 1'b1;
            end else begin
                cnt_n      = {{(CNT_W-1){1'b0}}, 1'b1};
                cnt_type_n = sh_type;
            end
        end
        if (err_n)   cnt_n = '0;
        if (cnt_clr) cnt_n = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 4'd0;
            skpn        <= '0;
            sh_link     <= 8'd0;
            sh_lane     <= 8'd0;
            sh_nfts     <= 8'd0;
            sh_rate     <= 8'd0;
            sh_tctl     <= 8'd0;
            sh_type     <= 1'b0;
            ts1_det     <= 1'b0;
            ts2_det     <= 1'b0;
            skp_det     <= 1'b0;
            os_err      <= 1'b0;
            os_link     <= 8'd0;
            os_lane     <= 8'd0;
            os_nfts     <= 8'd0;
            os_rate     <= 8'd0;
            os_tctl     <= 8'd0;
            ts_cnt      <= '0;
            ts_cnt_type <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            skpn        <= skpn_n;
            sh_link     <= sh_link_n;
            sh_lane     <= sh_lane_n;
            sh_nfts     <= sh_nfts_n;
            sh_rate     <= sh_rate_n;
            sh_tctl     <= sh_tctl_n;
            sh_type     <= sh_type_n;
            ts1_det     <= ts1_n;
            ts2_det     <= ts2_n;
            skp_det     <= skp_n;
            os_err      <= err_n;
            ts_cnt      <= cnt_n;
            ts_cnt_type <= cnt_type_n;
            if (done) begin
                os_link <= sh_link;
                os_lane <= sh_lane;
                os_nfts <= sh_nfts;
                os_rate <= sh_rate;
                os_tctl <= sh_tctl;
            end
        end
    end
endmodule

// File: tb/tb_tx_os_decoder.sv
// Scoreboard bench for tx_os_decoder: expected OS events are queued as stimulus is
// driven and matched (content and cycle) against every output pulse.
module tb_tx_os_decoder;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] txdata;
    logic       txdatak, txvalid, cnt_clr;
    logic       ts1_det, ts2_det, skp_det, os_err;
    logic [7:0] os_link, os_lane, os_nfts, os_rate, os_tctl;
    logic [3:0] ts_cnt;
    logic       ts_cnt_type;

    tx_os_decoder #(.SKP_LEN(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .txdata(txdata), .txdatak(txdatak), .txvalid(txvalid),
        .cnt_clr(cnt_clr), .ts1_det(ts1_det), .ts2_det(ts2_det), .skp_det(skp_det),
        .os_err(os_err), .os_link(os_link), .os_lane(os_lane), .os_nfts(os_nfts),
        .os_rate(os_rate), .os_tctl(os_tctl), .ts_cnt(ts_cnt), .ts_cnt_type(ts_cnt_type)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] COM = 8'hBC, SKPS = 8'h1C, PAD = 8'hF7;
    localparam logic [1:0] K_TS1 = 2'd0, K_TS2 = 2'd1, K_SKP = 2'd2, K_ERR = 2'd3;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] link, lane, nfts, rate, tctl;
        logic [3:0] cnt;
        logic       typ;
        int         cyc;
    } ev_t;

    ev_t sbq[$];
    int  checks = 0, failures = 0, cyc = 0;

    // reference state: last good TS fields and running count
    logic [7:0] m_link = 0, m_lane = 0, m_nfts = 0, m_rate = 0, m_tctl = 0;
    logic [3:0] m_cnt = 0;
    logic       m_type = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    int  np;
    ev_t e;
    logic [1:0] got_kind;
    always @(negedge clk) begin
        np = int'(ts1_det) + int'(ts2_det) + int'(skp_det) + int'(os_err);
        if (np > 0) begin
            chk("onehot", (np <= 1), 1);
            got_kind = ts2_det ? K_TS2 : skp_det ? K_SKP : os_err ? K_ERR : K_TS1;
            if (sbq.size() == 0) begin
                chk("spurious_pulse", np, 0);
            end else begin
                e = sbq.pop_front();
                chk("kind", got_kind, e.kind);
                chk("cycle", cyc, e.cyc);
                chk("os_link", os_link, e.link);
                chk("os_lane", os_lane, e.lane);
                chk("os_nfts", os_nfts, e.nfts);
                chk("os_rate", os_rate, e.rate);
                chk("os_tctl", os_tctl, e.tctl);
                chk("ts_cnt", ts_cnt, e.cnt);
                chk("ts_cnt_type", ts_cnt_type, e.typ);
            end
        end
    end

    task automatic push(input logic [1:0] kind);
        ev_t x;
        x.kind = kind; x.link = m_link; x.lane = m_lane; x.nfts = m_nfts;
        x.rate = m_rate; x.tctl = m_tctl; x.cnt = m_cnt; x.typ = m_type; x.cyc = cyc + 1;
        sbq.push_back(x);
    endtask

    task automatic sym(input logic k, input logic [7:0] d);
        txvalid = 1'b1; txdatak = k; txdata = d;
        @(posedge clk); #1;
    endtask

    task automatic send_ts(input bit t2, input bit lpad, input logic [7:0] link, lane, nfts,
                           rate, tctl, input int gap, input bit clr);
        logic [7:0] id, lnk;
        bit match;
        id  = t2 ? 8'h45 : 8'h4A;
        lnk = lpad ? PAD : link;
        sym(1'b1, COM);
        sym(lpad, lnk);
        sym(1'b0, lane);
        sym(1'b0, nfts);
        sym(1'b0, rate);
        if (gap > 0) begin
            // held-off cycles carry a COM that must not be seen
            txvalid = 1'b0; txdatak = 1'b1; txdata = COM;
            repeat (gap) @(posedge clk);
            #1;
        end
        sym(1'b0, tctl);
        for (int i = 6; i < 15; i++) sym(1'b0, id);
        match = (t2 == m_type) && (lnk == m_link) && (lane == m_lane) && (rate == m_rate);
        m_link = lnk; m_lane = lane; m_nfts = nfts; m_rate = rate; m_tctl = tctl;
        if (match) m_cnt = (m_cnt == 4'hF) ? 4'hF : m_cnt + 4'd1;
        else begin
            m_cnt = 4'd1; m_type = t2;
        end
        if (clr) m_cnt = 4'd0;
        push(t2 ? K_TS2 : K_TS1);
        cnt_clr = clr;
        sym(1'b0, id);
        cnt_clr = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pulses"}, {ts1_det, ts2_det, skp_det, os_err}, 0);
        chk({tag, "_fields"}, {os_link, os_lane, os_nfts, os_rate}, 0);
        chk({tag, "_tctl_cnt"}, {os_tctl, ts_cnt, ts_cnt_type}, 0);
    endtask

    initial begin
        rst = 1'b1; txvalid = 1'b0; txdatak = 1'b0; txdata = 8'h00; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // basic TS1
        send_ts(0, 0, 8'h01, 8'h00, 8'h1F, 8'h02, 8'h00, 0, 0);
        // TS2 with PAD link: 8 then 10 more to saturate
        for (int i = 0; i < 18; i++) send_ts(1, 1, 8'h00, 8'h00, 8'h10, 8'h02, 8'h00, 0, 0);
        // TS1 x3, SKP OS, TS1, then lane change
        for (int i = 0; i < 3; i++) send_ts(0, 0, 8'h03, 8'h01, 8'h20, 8'h02, 8'h04, 0, 0);
        sym(1'b1, COM); sym(1'b1, SKPS); sym(1'b1, SKPS);
        push(K_SKP);
        sym(1'b1, SKPS);
        send_ts(0, 0, 8'h03, 8'h01, 8'h20, 8'h02, 8'h04, 0, 0);
        send_ts(0, 0, 8'h03, 8'h02, 8'h20, 8'h02, 8'h04, 0, 0);

        // wrong ID at symbol 9
        sym(1'b1, COM); sym(1'b0, 8'h03); sym(1'b0, 8'h02); sym(1'b0, 8'h20);
        sym(1'b0, 8'h02); sym(1'b0, 8'h04);
        for (int i = 6; i < 9; i++) sym(1'b0, 8'h4A);
        m_cnt = 4'd0;
        push(K_ERR);
        sym(1'b0, 8'h45);
        txvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // COM at idx8 restarts, then full TS1
        sym(1'b1, COM); sym(1'b0, 8'h03); sym(1'b0, 8'h02); sym(1'b0, 8'h20);
        sym(1'b0, 8'h02); sym(1'b0, 8'h04); sym(1'b0, 8'h4A); sym(1'b0, 8'h4A);
        m_cnt = 4'd0;
        push(K_ERR);
        send_ts(0, 0, 8'h03, 8'h02, 8'h20, 8'h02, 8'h04, 0, 0);

        // txvalid gap at idx4
        send_ts(0, 0, 8'h03, 8'h02, 8'h21, 8'h02, 8'h05, 5, 0);

        // cnt_clr on third identical TS1
        send_ts(0, 0, 8'h05, 8'h07, 8'h30, 8'h02, 8'h00, 0, 0);
        send_ts(0, 0, 8'h05, 8'h07, 8'h30, 8'h02, 8'h00, 0, 0);
        send_ts(0, 0, 8'h05, 8'h07, 8'h30, 8'h02, 8'h00, 0, 1);

        // reset mid-OS at idx10
        sym(1'b1, COM); sym(1'b0, 8'h05); sym(1'b0, 8'h07); sym(1'b0, 8'h30);
        sym(1'b0, 8'h02); sym(1'b0, 8'h00);
        for (int i = 6; i < 10; i++) sym(1'b0, 8'h4A);
        txdata = 8'h4A;
        rst = 1'b1;
        #2;
        chk_zero("midos_reset");
        m_link = 0; m_lane = 0; m_nfts = 0; m_rate = 0; m_tctl = 0; m_cnt = 0; m_type = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 11; i < 16; i++) sym(1'b0, 8'h4A);
        txvalid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_zero("post_reset");

        // after reset, a fresh TS counts from 1
        send_ts(0, 0, 8'h01, 8'h00, 8'h1F, 8'h02, 8'h00, 0, 0);
        txvalid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
